// File: rtl/serial_digit_adder_pkg.sv
// rtl/serial_digit_adder_pkg.sv - shared states and sizing helpers for the serial digit adder
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STATE_W = 2;

  // Number of digits processed per operation.
  function automatic int digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width: $clog2(N), but never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Legal parameter pairs: DIGIT in 1..WIDTH and WIDTH an exact multiple of DIGIT.
  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_ripple_adder.sv
// rtl/digit_ripple_adder.sv - combinational DIGIT-bit ripple-carry slice
module digit_ripple_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - digit-serial adder top; optional scan chain via SERIAL_DIGIT_ADDER_SCAN_EN
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
  ,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
`endif
);

  localparam int N     = digits(WIDTH, DIGIT);
  localparam int CNT_W = cnt_width(N);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_digit_adder: WIDTH must be a multiple of DIGIT and DIGIT in 1..WIDTH");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               co_q, co_d;

  logic [DIGIT-1:0]   dig_s;
  logic               dig_co;
  logic [WIDTH-1:0]   dig_ext;

  digit_ripple_adder #(.DIGIT(DIGIT)) u_slice (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // New digit enters at the top of the sum register; a full operation leaves it aligned.
  assign dig_ext = WIDTH'(dig_s);

`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
  localparam int L = STATE_W + CNT_W + 1 + 3 * WIDTH + 1;

  logic [L-1:0]       chain, shifted;
  logic [STATE_W-1:0] st_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               carry_s, co_s;
  logic [WIDTH-1:0]   a_s, b_s, sum_s;

  assign chain    = {state_q, cnt_q, carry_q, a_q, b_q, sum_q, co_q};
  assign shifted  = {scan_in, chain[L-1:1]};
  assign {st_s, cnt_s, carry_s, a_s, b_s, sum_s, co_s} = shifted;
  assign scan_out = co_q;

  assign in_ready  = (state_q == IDLE) && !scan_en;
  assign out_valid = (state_q == DONE) && !scan_en;
`else
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
`endif

  assign sum = sum_q;
  assign co  = co_q;

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          co_d    = dig_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State flops: async reset, scan shift when enabled, otherwise functional update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end
`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
    else if (scan_en) begin
      state_q <= state_t'(st_s);
      cnt_q   <= cnt_s;
      carry_q <= carry_s;
      a_q     <= a_s;
      b_q     <= b_s;
      sum_q   <= sum_s;
      co_q    <= co_s;
    end
`endif
    else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb/tb_serial_digit_adder.sv - directed and random checks for serial_digit_adder (DIGIT 4, 1, 16)
module tb_serial_digit_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, out_ready;
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic [15:0] s  [3];
  logic        c  [3];
  logic        se [3];
  logic        si [3];
  logic        so [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(s[0]), .co(c[0])
`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
    , .scan_en(se[0]), .scan_in(si[0]), .scan_out(so[0])
`endif
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(s[1]), .co(c[1])
`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
    , .scan_en(se[1]), .scan_in(si[1]), .scan_out(so[1])
`endif
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(s[2]), .co(c[2])
`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
    , .scan_en(se[2]), .scan_in(si[2]), .scan_out(so[2])
`endif
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic [15:0] esum;
    logic        eco;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation on instance k; inputs are scrambled right after the accepting edge.
  task automatic start_op(input int k, input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    int guard = 0;
    while (!ir[k] && guard < 100) begin
      tick();
      guard++;
    end
    check("accept_ready", 32'(ir[k]), 32'd1);
    a = ta; b = tb; cin = tc; iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc;
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 100) begin
      tick();
      lat++;
    end
    if (!ov[k]) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int exp_lat [3];
    logic [16:0] ref_v;
    logic [15:0] ra, rb;
    logic        rc;

    exp_lat[0] = 4; exp_lat[1] = 16; exp_lat[2] = 1;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; se[k] = 1'b0; si[k] = 1'b0;
    end
    tick();
    tick();
    check("reset_in_ready", 32'(ir[0]), 32'd1);
    check("reset_out_valid", 32'(ov[0]), 32'd0);
    check("reset_sum", 32'(s[0]), 32'd0);
    check("reset_co", 32'(c[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors on the DIGIT=4 instance.
    for (int i = 0; i < 8; i++) begin
      start_op(0, vecs[i].va, vecs[i].vb, vecs[i].vcin);
      wait_valid(0, lat);
      check($sformatf("vec%0d_sum", i), 32'(s[0]), 32'(vecs[i].esum));
      check($sformatf("vec%0d_co", i), 32'(c[0]), 32'(vecs[i].eco));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      tick();
      check($sformatf("vec%0d_valid_pulse", i), 32'(ov[0]), 32'd0);
      check($sformatf("vec%0d_idle_ready", i), 32'(ir[0]), 32'd1);
    end

    // Backpressure: hold out_ready low for 10 cycles, with a stray in_valid pulse.
    out_ready = 1'b0;
    start_op(0, 16'h1234, 16'h4321, 1'b0);
    wait_valid(0, lat);
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", 32'(ov[0]), 32'd1);
      check("hold_in_ready", 32'(ir[0]), 32'd0);
      check("hold_sum", 32'(s[0]), 32'h5555);
      check("hold_co", 32'(c[0]), 32'd0);
      iv[0] = (i == 3);
      a = 16'hFFFF; b = 16'hFFFF;
      tick();
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_out_valid", 32'(ov[0]), 32'd0);
    check("release_in_ready", 32'(ir[0]), 32'd1);
    check("release_sum_kept", 32'(s[0]), 32'h5555);

    // Reset during the second RUN cycle.
    start_op(0, 16'h1234, 16'h4321, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(ov[0]), 32'd0);
    check("abort_sum", 32'(s[0]), 32'd0);
    check("abort_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 32'(ov[0]), 32'd0);
    end
    start_op(0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_valid(0, lat);
    check("after_abort_sum", 32'(s[0]), 32'h1000);
    check("after_abort_co", 32'(c[0]), 32'd0);
    tick();

    // Random sweep on DIGIT = 4, 1, 16.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 200; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        ref_v = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
        start_op(k, ra, rb, rc);
        wait_valid(k, lat);
        check($sformatf("sweep%0d_result", k), 32'({c[k], s[k]}), 32'(ref_v));
        check($sformatf("sweep%0d_latency", k), 32'(lat), 32'(exp_lat[k]));
        tick();
      end
    end

`ifdef SERIAL_DIGIT_ADDER_SCAN_EN
    begin
      localparam int L = 2 + 2 + 1 + 48 + 1;
      logic [7:0] pat = 8'hA5;
      se[0] = 1'b1;
      for (int i = 0; i < L; i++) begin
        si[0] = pat[7 - (i % 8)];
        tick();
      end
      for (int i = 0; i < L; i++) begin
        check("scan_shift", 32'(so[0]), 32'(pat[7 - (i % 8)]));
        si[0] = 1'b0;
        tick();
      end
      se[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      start_op(0, 16'h1234, 16'h4321, 1'b0);
      tick();
      se[0] = 1'b1;
      for (int i = 0; i < L; i++) begin
        si[0] = so[0];
        if (i == 2) check("scan_out_valid_low", 32'(ov[0]), 32'd0);
        tick();
      end
      se[0] = 1'b0;
      wait_valid(0, lat);
      check("scan_resume_sum", 32'(s[0]), 32'h5555);
      check("scan_resume_co", 32'(c[0]), 32'd0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
